// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : EX-side branch resolution. Keeps an in-order queue of the
//                predictions made at fetch, pairs each EX resolution with the
//                oldest one, flags mispredicts, drives the predictor update
//                port and the pipeline flush/redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    // prediction records from fetch
    input  logic                 push_valid,
    input  logic [XLEN-1:0]      push_pc,
    input  logic                 push_pred_taken,
    input  logic [XLEN-1:0]      push_pred_target,
    output logic                 push_ready,
    // resolutions from execute
    input  logic                 res_valid,
    input  logic [XLEN-1:0]      res_pc,
    input  logic                 res_taken,
    input  logic [XLEN-1:0]      res_target,
    input  logic                 res_is_branch,
    input  logic                 ext_flush,
    // predictor update port
    output logic                 update_en,
    output logic [XLEN-1:0]      update_pc,
    output logic                 actual_taken,
    output logic [XLEN-1:0]      actual_target,
    output logic                 is_branch,
    // pipeline control
    output logic                 mispredict_flush,
    output logic [XLEN-1:0]      redirect_pc,
    // performance counters
    output logic [CNT_WIDTH-1:0] resolve_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int                 c_PW       = $clog2(QUEUE_DEPTH);
    localparam logic [c_PW:0]      c_DEPTH    = QUEUE_DEPTH[c_PW:0];
    localparam logic [c_PW:0]      c_CNT_ONE  = {{c_PW{1'b0}}, 1'b1};
    localparam logic [c_PW-1:0]    c_PTR_ONE  = {{(c_PW-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_PERF_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]    c_FOUR     = {{(XLEN-3){1'b0}}, 3'b100};

    // prediction storage
    logic [XLEN-1:0] r_q_pc     [QUEUE_DEPTH];
    logic            r_q_taken  [QUEUE_DEPTH];
    logic [XLEN-1:0] r_q_target [QUEUE_DEPTH];

    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW:0]   r_count;

    logic            w_empty;
    logic            w_match;
    logic            w_mispredict;
    logic            w_res_acc;
    logic            w_push;
    logic            w_pop;
    logic            w_clear;
    logic [XLEN-1:0] w_redirect;

    // queue status, head comparison and per-cycle decisions
    always_comb begin
        push_ready   = (r_count != c_DEPTH);
        w_empty      = (r_count == '0);
        w_match      = !w_empty && (r_q_pc[r_rd_ptr] == res_pc);
        // an unmatched resolution means the fetch stream is off the rails
        w_mispredict = !w_match
                     || (r_q_taken[r_rd_ptr] != res_taken)
                     || (res_taken && (r_q_target[r_rd_ptr] != res_target));
        w_res_acc    = res_valid && !ext_flush;
        w_clear      = ext_flush || (w_res_acc && w_mispredict);
        w_pop        = w_res_acc && !w_mispredict;
        // a push alongside any clear is wrong-path and discarded
        w_push       = push_valid && push_ready && !w_clear;
        w_redirect   = res_taken ? res_target : (res_pc + c_FOUR);
    end

    // entry payload write; stale slots are never read because count gates them
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_q_pc[r_wr_ptr]     <= push_pc;
            r_q_taken[r_wr_ptr]  <= push_pred_taken;
            r_q_target[r_wr_ptr] <= push_pred_target;
        end
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // registered update/flush outputs and performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            update_en        <= 1'b0;
            update_pc        <= '0;
            actual_taken     <= 1'b0;
            actual_target    <= '0;
            is_branch        <= 1'b0;
            mispredict_flush <= 1'b0;
            redirect_pc      <= '0;
            resolve_count    <= '0;
            mispredict_count <= '0;
        end else begin
            update_en        <= w_res_acc;
            mispredict_flush <= w_res_acc && w_mispredict;
            if (w_res_acc) begin
                update_pc     <= res_pc;
                actual_taken  <= res_taken;
                actual_target <= res_target;
                is_branch     <= res_is_branch;
                resolve_count <= resolve_count + c_PERF_ONE;
                if (w_mispredict) begin
                    mispredict_count <= mispredict_count + c_PERF_ONE;
                    redirect_pc      <= w_redirect;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Self-checking bench for branch_resolve_unit with a queue-based
//                reference model and directed plus randomized scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_target;
    logic        push_ready;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_is_branch;
    logic        ext_flush;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic [31:0] actual_target;
    logic        is_branch;
    logic        mispredict_flush;
    logic [31:0] redirect_pc;
    logic [31:0] resolve_count;
    logic [31:0] mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .QUEUE_DEPTH(4), .CNT_WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .push_ready       (push_ready),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .res_is_branch    (res_is_branch),
        .ext_flush        (ext_flush),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .actual_taken     (actual_taken),
        .actual_target    (actual_target),
        .is_branch        (is_branch),
        .mispredict_flush (mispredict_flush),
        .redirect_pc      (redirect_pc),
        .resolve_count    (resolve_count),
        .mispredict_count (mispredict_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        t;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    logic        e_uen, e_tk, e_br, e_fl;
    logic [31:0] e_upc, e_tgt, e_redir, e_rc, e_mc;

    task automatic model_update();
        bit   hit, mis, can_push;
        ent_t ne;
        if (reset) begin
            mq.delete();
            e_uen = 0; e_tk = 0; e_br = 0; e_fl = 0;
            e_upc = 0; e_tgt = 0; e_redir = 0; e_rc = 0; e_mc = 0;
        end else if (ext_flush) begin
            mq.delete();
            e_uen = 0; e_fl = 0;
        end else begin
            can_push = push_valid && (mq.size() < 4);
            mis = 0;
            if (res_valid) begin
                hit = (mq.size() > 0) && (mq[0].pc == res_pc);
                if (!hit) mis = 1;
                else if (mq[0].t != res_taken) mis = 1;
                else if (res_taken && (mq[0].tgt != res_target)) mis = 1;
                e_uen = 1; e_upc = res_pc; e_tk = res_taken;
                e_tgt = res_target; e_br = res_is_branch; e_fl = mis;
                e_rc  = e_rc + 1;
                if (mis) begin
                    e_mc    = e_mc + 1;
                    e_redir = res_taken ? res_target : res_pc + 32'd4;
                end
            end else begin
                e_uen = 0; e_fl = 0;
            end
            if (mis) begin
                mq.delete();
            end else begin
                if (res_valid) void'(mq.pop_front());
                if (can_push) begin
                    ne.pc = push_pc; ne.t = push_pred_taken; ne.tgt = push_pred_target;
                    mq.push_back(ne);
                end
            end
        end
    endtask

    // advance one clock; model sees the same inputs as the DUT
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic pt,
                         input logic [31:0] ptg, input logic rv, input logic [31:0] rpc,
                         input logic rt, input logic [31:0] rtg, input logic rbr,
                         input logic ef);
        push_valid = pv; push_pc = ppc; push_pred_taken = pt; push_pred_target = ptg;
        res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg;
        res_is_branch = rbr; ext_flush = ef;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1; idle();
        step(); step();
        reset = 0;
        step();
        n_tests++;
        if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready got=%0b exp=1", push_ready); end
        n_tests++;
        if (update_en !== 1'b0 || mispredict_flush !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses got uen=%0b fl=%0b exp=0/0", update_en, mispredict_flush);
        end
        n_tests++;
        if (resolve_count !== 32'd0 || mispredict_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters got rc=%0d mc=%0d exp=0/0", resolve_count, mispredict_count);
        end
        n_tests++;
        if (redirect_pc !== 32'd0 || update_pc !== 32'd0) begin
            n_fail++; $display("FAIL reset_regs got redir=%h upc=%h exp=0/0", redirect_pc, update_pc);
        end
    endtask

    task automatic test_correct();
        drive(1, 32'h100, 1, 32'h140, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 32'h100, 1, 32'h140, 1, 0); step();
        n_tests++;
        if (update_en !== 1 || update_pc !== 32'h100 || actual_taken !== 1 || is_branch !== 1
            || actual_target !== 32'h140) begin
            n_fail++; $display("FAIL correct_update got en=%0b pc=%h tk=%0b tgt=%h br=%0b exp=1/100/1/140/1",
                               update_en, update_pc, actual_taken, actual_target, is_branch);
        end
        n_tests++;
        if (mispredict_flush !== 0) begin n_fail++; $display("FAIL correct_noflush got=%0b exp=0", mispredict_flush); end
        n_tests++;
        if (resolve_count !== e_rc || e_rc !== 32'd1) begin
            n_fail++; $display("FAIL correct_rc got=%0d exp=1", resolve_count);
        end
        idle(); step();
        n_tests++;
        if (update_en !== 0) begin n_fail++; $display("FAIL correct_pulse got=%0b exp=0", update_en); end
    endtask

    task automatic test_mispredict();
        drive(1, 32'h200, 0, 32'h0,   0, 0, 0, 0, 0, 0); step();
        drive(1, 32'h204, 1, 32'h300, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 32'h200, 1, 32'h180, 1, 0); step();
        n_tests++;
        if (mispredict_flush !== 1 || redirect_pc !== 32'h180) begin
            n_fail++; $display("FAIL mp_dir got fl=%0b redir=%h exp=1/180", mispredict_flush, redirect_pc);
        end
        n_tests++;
        if (mispredict_count !== e_mc || e_mc !== 32'd1) begin
            n_fail++; $display("FAIL mp_count got=%0d exp=1", mispredict_count);
        end
        drive(0, 0, 0, 0, 1, 32'h204, 0, 32'h300, 1, 0); step();
        n_tests++;
        if (mispredict_flush !== 1 || redirect_pc !== 32'h208) begin
            n_fail++; $display("FAIL mp_unmatched got fl=%0b redir=%h exp=1/208", mispredict_flush, redirect_pc);
        end
        idle(); step();
        n_tests++;
        if (mispredict_flush !== 0) begin n_fail++; $display("FAIL mp_pulse got=%0b exp=0", mispredict_flush); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h10 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0, 0, 0); step();
        end
        n_tests++;
        if (push_ready !== 0) begin n_fail++; $display("FAIL full_ready got=%0b exp=0", push_ready); end
        drive(1, 32'h20, 0, 32'h0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 32'h10, 0, 32'h0, 1, 0); step();
        n_tests++;
        if (push_ready !== 1 || mispredict_flush !== 0) begin
            n_fail++; $display("FAIL full_pop got rdy=%0b fl=%0b exp=1/0", push_ready, mispredict_flush);
        end
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 32'h10 + 32'(4 * i), 0, 32'h0, 1, 0); step();
            n_tests++;
            if (mispredict_flush !== 0) begin
                n_fail++; $display("FAIL full_order entry=%0d got fl=%0b exp=0", i, mispredict_flush);
            end
        end
        // the dropped fifth entry must not be there
        drive(0, 0, 0, 0, 1, 32'h20, 0, 32'h0, 1, 0); step();
        n_tests++;
        if (mispredict_flush !== 1) begin n_fail++; $display("FAIL full_drop got fl=%0b exp=1", mispredict_flush); end
        idle(); step();
    endtask

    task automatic test_nt_target();
        drive(1, 32'h700, 0, 32'h111, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 32'h700, 0, 32'h704, 1, 0); step();
        n_tests++;
        if (mispredict_flush !== 0 || update_en !== 1) begin
            n_fail++; $display("FAIL nt_target got fl=%0b en=%0b exp=0/1", mispredict_flush, update_en);
        end
        idle(); step();
    endtask

    task automatic test_jalr();
        drive(1, 32'h400, 1, 32'h480, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 32'h400, 1, 32'h500, 0, 0); step();
        n_tests++;
        if (mispredict_flush !== 1 || redirect_pc !== 32'h500 || is_branch !== 0 || update_en !== 1) begin
            n_fail++; $display("FAIL jalr got fl=%0b redir=%h br=%0b en=%0b exp=1/500/0/1",
                               mispredict_flush, redirect_pc, is_branch, update_en);
        end
        idle(); step();
    endtask

    task automatic test_ext_flush();
        logic [31:0] rc0, mc0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h600 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0, 0, 0); step();
        end
        rc0 = e_rc; mc0 = e_mc;
        drive(1, 32'h60c, 0, 32'h0, 1, 32'h600, 0, 32'h0, 1, 1); step();
        n_tests++;
        if (update_en !== 0 || mispredict_flush !== 0) begin
            n_fail++; $display("FAIL xflush_pulses got en=%0b fl=%0b exp=0/0", update_en, mispredict_flush);
        end
        n_tests++;
        if (resolve_count !== rc0 || mispredict_count !== mc0) begin
            n_fail++; $display("FAIL xflush_counters got rc=%0d mc=%0d exp=%0d/%0d",
                               resolve_count, mispredict_count, rc0, mc0);
        end
        drive(0, 0, 0, 0, 1, 32'h604, 0, 32'h0, 1, 0); step();
        n_tests++;
        if (mispredict_flush !== 1) begin n_fail++; $display("FAIL xflush_empty got fl=%0b exp=1", mispredict_flush); end
        idle(); step();
    endtask

    task automatic test_back_to_back_random();
        logic        rv, rt, pt;
        logic [31:0] rpc, rtg, ppc, ptg;
        for (int c = 0; c < 600; c++) begin
            ppc = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            pt  = 1'($urandom_range(0, 1));
            ptg = $urandom_range(0, 1) ? 32'h2000 : 32'h2040;
            rv  = ($urandom_range(0, 1) == 1);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rpc = mq[0].pc;
                rt  = ($urandom_range(0, 3) != 0) ? mq[0].t : ~mq[0].t;
                rtg = ($urandom_range(0, 3) != 0) ? mq[0].tgt : 32'h3000;
            end else begin
                rpc = 32'h1000 + 32'(4 * $urandom_range(0, 7));
                rt  = 1'($urandom_range(0, 1));
                rtg = 32'h2000;
            end
            drive(1'($urandom_range(0, 1)), ppc, pt, ptg, rv, rpc, rt, rtg,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
            n_tests++;
            if (push_ready !== (mq.size() != 4)) begin
                n_fail++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", c, push_ready, mq.size() != 4);
            end
            step();
            n_tests++;
            if (update_en !== e_uen || mispredict_flush !== e_fl) begin
                n_fail++; $display("FAIL rnd_pulses cyc=%0d got en=%0b fl=%0b exp=%0b/%0b",
                                   c, update_en, mispredict_flush, e_uen, e_fl);
            end
            n_tests++;
            if (update_pc !== e_upc || actual_taken !== e_tk || actual_target !== e_tgt || is_branch !== e_br) begin
                n_fail++; $display("FAIL rnd_update cyc=%0d got pc=%h tk=%0b tgt=%h br=%0b exp=%h/%0b/%h/%0b",
                                   c, update_pc, actual_taken, actual_target, is_branch, e_upc, e_tk, e_tgt, e_br);
            end
            n_tests++;
            if (redirect_pc !== e_redir || resolve_count !== e_rc || mispredict_count !== e_mc) begin
                n_fail++; $display("FAIL rnd_misc cyc=%0d got redir=%h rc=%0d mc=%0d exp=%h/%0d/%0d",
                                   c, redirect_pc, resolve_count, mispredict_count, e_redir, e_rc, e_mc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_mispredict();
        test_full();
        test_nt_target();
        test_jalr();
        test_ext_flush();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
